// File: rtl/fetch_attr_issue_ctrl_pkg.sv
// Shared types for the fetch-attributes FIFO controller: the per-request
// attribute record and the controller FSM encoding.
package fetch_attr_pkg;

    localparam int PC_W                    = 32;
    localparam int INSTR_W                 = 32;
    localparam int MAX_OUTSTANDING_DEFAULT = 4;

    typedef struct packed {
        logic [PC_W-1:0] pc;
    } attr_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } issue_state_e;

endpackage

// File: rtl/fetch_attr_issue_ctrl_if.sv
// Handshake bundle between the issue controller and its PC stage, instruction
// memory, attribute FIFO and fetch buffer.
interface fetch_attr_issue_ctrl_if
    import fetch_attr_pkg::*;
#(
    parameter int ADDR_W = PC_W,
    parameter int DATA_W = INSTR_W
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_pc;
    logic              req_ready;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    logic              fifo_push;
    logic              fifo_potential_push;
    attr_t             fifo_data_in;
    logic              fifo_pop;
    logic              fifo_valid;
    logic              fifo_full;
    attr_t             fifo_data_out;

    logic              out_valid;
    logic [ADDR_W-1:0] out_pc;
    logic [DATA_W-1:0] out_data;

    modport master (
        input  req_valid, req_pc, mem_ready, mem_rvalid, mem_rdata,
               fifo_valid, fifo_full, fifo_data_out,
        output req_ready, mem_req, mem_addr, fifo_push, fifo_potential_push,
               fifo_data_in, fifo_pop, out_valid, out_pc, out_data
    );

    modport slave (
        output req_valid, req_pc, mem_ready, mem_rvalid, mem_rdata,
               fifo_valid, fifo_full, fifo_data_out,
        input  req_ready, mem_req, mem_addr, fifo_push, fifo_potential_push,
               fifo_data_in, fifo_pop, out_valid, out_pc, out_data
    );

endinterface

// File: rtl/fetch_attr_issue_ctrl.sv
// Issues fetch requests to instruction memory, tracks them through the attribute
// FIFO and forwards in-order responses; after a flush, drains in-flight responses.
module fetch_attr_issue_ctrl
    import fetch_attr_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
    parameter int ADDR_W          = PC_W,
    parameter int DATA_W          = INSTR_W,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    fetch_attr_issue_ctrl_if.master    bus,
    output logic [CNT_W-1:0]           outstanding
);

    issue_state_e      state_q, state_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  drain_q, drain_d;
    logic              resp, can_issue, issue, fwd;
    logic              out_valid_q;
    logic [ADDR_W-1:0] out_pc_q;
    logic [DATA_W-1:0] out_data_q;

    assign resp = bus.mem_rvalid;

    // A same-cycle response frees both a FIFO slot and a credit.
    assign can_issue = (state_q == RUN) && !flush && bus.mem_ready
                    && (!bus.fifo_full || resp)
                    && ((outstanding_q < CNT_W'(MAX_OUTSTANDING)) || resp);
    assign issue     = can_issue && bus.req_valid;
    assign fwd       = resp && !flush && (drain_q == '0);

    assign bus.req_ready           = can_issue;
    assign bus.mem_req             = issue;
    assign bus.mem_addr            = bus.req_pc;
    assign bus.fifo_push           = issue;
    assign bus.fifo_potential_push = bus.req_valid && (state_q == RUN);
    assign bus.fifo_pop            = resp;
    assign bus.out_valid           = out_valid_q;
    assign bus.out_pc              = out_pc_q;
    assign bus.out_data            = out_data_q;
    assign outstanding             = outstanding_q;

    always_comb begin
        bus.fifo_data_in    = '0;
        bus.fifo_data_in.pc = bus.req_pc;
    end

    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(resp);
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            RUN: begin
                if (flush) begin
                    // The response arriving with the flush is dropped here.
                    drain_d = outstanding_q - CNT_W'(resp);
                    if (drain_d != '0) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A repeated flush changes nothing: everything is already marked.
                if (resp) begin
                    drain_d = drain_q - 1'b1;
                    if (drain_q == CNT_W'(1)) state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                drain_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            outstanding_q <= '0;
            drain_q       <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            drain_q       <= drain_d;
            out_valid_q   <= fwd;
        end
    end

    always_ff @(posedge clk) begin
        if (fwd) begin
            out_pc_q   <= bus.fifo_data_out.pc;
            out_data_q <= bus.mem_rdata;
        end
    end

    a_resp_has_record: assert property (@(posedge clk) disable iff (rst)
        bus.mem_rvalid |-> (bus.fifo_valid && outstanding_q != '0));

endmodule

// File: tb/tb_fetch_attr_issue_ctrl.sv
// Bench for fetch_attr_issue_ctrl: combinational vector table, directed corner
// sequences and random traffic against a queue-based model of in-flight requests.
module tb_fetch_attr_issue_ctrl;
    import fetch_attr_pkg::*;

    localparam int MAXO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [2:0] outstanding;

    fetch_attr_issue_ctrl_if bus();

    fetch_attr_issue_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        bit          drop;
    } ent_t;

    typedef struct {
        bit rv, mr, full, fl;
        bit exp_rdy, exp_push, exp_pp;
    } vec_t;

    ent_t        inf[$];
    bit          exp_ov;
    logic [31:0] exp_pc, exp_data;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(bit rv, logic [31:0] pc, bit mr, bit rsp, logic [31:0] rd, bit fl);
        bus.req_valid  = rv;
        bus.req_pc     = pc;
        bus.mem_ready  = mr;
        bus.mem_rvalid = rsp;
        bus.mem_rdata  = rd;
        flush          = fl;
    endtask

    // One clock: check combinational outputs against the model, clock, then
    // advance the model and check registered outputs.
    task automatic cycle();
        bit          resp, drain, rdy, issue, fl;
        logic [31:0] rd, pc;
        ent_t        e;
        #1;
        resp  = bus.mem_rvalid;
        fl    = flush;
        rd    = bus.mem_rdata;
        pc    = bus.req_pc;
        drain = (inf.size() > 0) && inf[0].drop;
        rdy   = !drain && !fl && bus.mem_ready && (!bus.fifo_full || resp)
             && ((inf.size() < MAXO) || resp);
        issue = rdy && bus.req_valid;
        if (!rst) begin
            chk("req_ready", bus.req_ready, rdy);
            chk("mem_req", bus.mem_req, issue);
            chk("fifo_push", bus.fifo_push, issue);
            chk("fifo_pop", bus.fifo_pop, resp);
            chk("potential_push", bus.fifo_potential_push, bus.req_valid && !drain);
            if (issue) begin
                chk("mem_addr", bus.mem_addr, pc);
                chk("fifo_data_in", bus.fifo_data_in.pc, pc);
            end
        end
        @(posedge clk);
        #1;
        exp_ov = 1'b0;
        if (rst) begin
            inf.delete();
        end else begin
            if (resp) begin
                e = inf.pop_front();
                if (!e.drop && !fl) begin
                    exp_ov   = 1'b1;
                    exp_pc   = e.pc;
                    exp_data = rd;
                end
            end
            if (fl) foreach (inf[i]) inf[i].drop = 1'b1;
            if (issue) inf.push_back('{pc: pc, drop: 1'b0});
        end
        chk("out_valid", bus.out_valid, exp_ov);
        if (exp_ov) begin
            chk("out_pc", bus.out_pc, exp_pc);
            chk("out_data", bus.out_data, exp_data);
        end
        chk("outstanding", outstanding, inf.size());
        bus.fifo_valid = inf.size() > 0;
        bus.fifo_full  = inf.size() >= MAXO;
        if (inf.size() > 0) bus.fifo_data_out.pc = inf[0].pc;
        else                bus.fifo_data_out.pc = '0;
    endtask

    task automatic go(bit rv, logic [31:0] pc, bit mr, bit rsp, logic [31:0] rd, bit fl);
        drive(rv, pc, mr, rsp, rd, fl);
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        rst = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1,1,0,0, 1,1,1};
        vecs[1] = '{0,1,0,0, 1,0,0};
        vecs[2] = '{1,0,0,0, 0,0,1};
        vecs[3] = '{1,1,1,0, 0,0,1};
        vecs[4] = '{1,1,0,1, 0,0,1};
        vecs[5] = '{0,0,1,1, 0,0,0};
        vecs[6] = '{1,0,1,1, 0,0,1};
        vecs[7] = '{0,1,1,0, 0,0,0};

        bus.fifo_valid         = 1'b0;
        bus.fifo_full          = 1'b0;
        bus.fifo_data_out      = '0;
        do_reset();
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_outstanding", outstanding, 0);

        // Combinational table, reset held so stray edges cannot change state.
        rst = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].rv, 32'h40, vecs[i].mr, 0, 0, vecs[i].fl);
            bus.fifo_full = vecs[i].full;
            #1;
            chk("vec_req_ready", bus.req_ready, vecs[i].exp_rdy);
            chk("vec_fifo_push", bus.fifo_push, vecs[i].exp_push);
            chk("vec_potential_push", bus.fifo_potential_push, vecs[i].exp_pp);
        end
        do_reset();

        // Basic flow
        go(1, 32'h100, 1, 0, 0, 0);      chk("basic_os1", outstanding, 1);
        go(1, 32'h104, 1, 0, 0, 0);      chk("basic_os2", outstanding, 2);
        go(0, 0, 1, 1, 32'hA, 0);
        chk("basic_v0", bus.out_valid, 1); chk("basic_pc0", bus.out_pc, 32'h100);
        chk("basic_d0", bus.out_data, 32'hA);
        go(0, 0, 1, 1, 32'hB, 0);
        chk("basic_pc1", bus.out_pc, 32'h104); chk("basic_d1", bus.out_data, 32'hB);
        chk("basic_os0", outstanding, 0);
        go(0, 0, 1, 0, 0, 0);             chk("basic_idle", bus.out_valid, 0);

        // Credit limit, then full FIFO with a coincident pop
        do_reset();
        for (int i = 0; i < 5; i++) go(1, 32'h200 + 4 * i, 1, 0, 0, 0);
        chk("credit_os", outstanding, 4);
        chk("credit_ready", bus.req_ready, 0);
        drive(1, 32'h214, 1, 1, 32'h55, 0);
        #1;
        chk("fullpop_push", bus.fifo_push, 1);
        chk("fullpop_pop", bus.fifo_pop, 1);
        cycle();
        chk("fullpop_os", outstanding, 4);
        chk("fullpop_pc", bus.out_pc, 32'h200);
        go(0, 0, 1, 1, 32'h66, 0);       chk("fullpop_head", bus.out_pc, 32'h204);
        for (int i = 0; i < 3; i++) go(0, 0, 1, 1, 32'h70 + i, 0);
        chk("fullpop_last", bus.out_pc, 32'h214);

        // Flush with three in flight
        do_reset();
        for (int i = 0; i < 3; i++) go(1, 32'h300 + 4 * i, 1, 0, 0, 0);
        go(1, 32'h30C, 1, 0, 0, 1);
        drive(1, 32'h30C, 1, 0, 0, 0);
        #1;
        chk("drain_ready", bus.req_ready, 0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            go(1, 32'h30C, 1, 1, 32'hD0 + i, 0);
            chk("drain_drop", bus.out_valid, 0);
        end
        go(1, 32'h30C, 1, 0, 0, 0);      chk("drain_reissue", outstanding, 1);
        go(0, 0, 1, 1, 32'h77, 0);
        chk("drain_fwd_pc", bus.out_pc, 32'h30C);

        // Flush with a coincident response, one in flight
        do_reset();
        go(1, 32'h400, 1, 0, 0, 0);
        go(1, 32'h404, 1, 1, 32'h88, 1);
        chk("flresp_drop", bus.out_valid, 0); chk("flresp_os", outstanding, 0);
        go(1, 32'h404, 1, 0, 0, 0);      chk("flresp_issue", outstanding, 1);
        go(0, 0, 1, 1, 32'h99, 0);       chk("flresp_pc", bus.out_pc, 32'h404);

        // Second flush during DRAIN, then reset during DRAIN
        do_reset();
        for (int i = 0; i < 3; i++) go(1, 32'h500 + 4 * i, 1, 0, 0, 0);
        go(0, 0, 1, 0, 0, 1);
        go(1, 32'h50C, 1, 1, 1, 0);
        go(1, 32'h50C, 1, 0, 0, 1);
        go(1, 32'h50C, 1, 1, 2, 0);
        go(1, 32'h50C, 1, 1, 3, 0);      chk("dflush_held", outstanding, 0);
        go(1, 32'h50C, 1, 0, 0, 0);      chk("dflush_issue", outstanding, 1);
        go(0, 0, 1, 1, 32'h5A, 0);       chk("dflush_pc", bus.out_pc, 32'h50C);
        go(1, 32'h510, 1, 0, 0, 0);
        go(1, 32'h514, 1, 0, 0, 0);
        go(0, 0, 1, 0, 0, 1);
        go(0, 0, 1, 1, 4, 0);
        do_reset();
        chk("rst_drain_os", outstanding, 0);
        chk("rst_drain_ov", bus.out_valid, 0);
        drive(1, 32'h600, 1, 0, 0, 0);
        #1;
        chk("rst_drain_ready", bus.req_ready, 1);
        cycle();
        go(0, 0, 1, 1, 32'h61, 0);       chk("rst_drain_pc", bus.out_pc, 32'h600);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            bit r, rs, fl;
            r  = ($urandom_range(0, 99) == 0);
            rs = !r && (inf.size() > 0) && ($urandom_range(0, 2) != 0);
            fl = !r && ($urandom_range(0, 24) == 0);
            rst = r;
            go($urandom_range(0, 1), $urandom, $urandom_range(0, 3) != 0, rs, $urandom, fl);
            rst = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_attr_issue_ctrl.md
Name: fetch_attr_issue_ctrl

Overview:
- Enqueue/dequeue controller for the fetch-attributes FIFO.
- Accepts fetch requests from the PC stage, issues them to instruction memory, and pushes a per-request attribute record into the FIFO.
- On each in-order memory response, pops the matching record and forwards the instruction with its PC to the fetch buffer.
- After a flush, discards responses for every request still in flight, using a drain counter.

Parameters:
- MAX_OUTSTANDING, 4: in-flight request limit; must not exceed the attached FIFO depth.
- ADDR_W, 32: PC width.
- DATA_W, 32: instruction width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  PC stage has a request
- req_pc  in  ADDR_W  request address
- req_ready  out  1  request issued this cycle when high with req_valid
- mem_req  out  1  memory request strobe
- mem_addr  out  ADDR_W  memory address (= req_pc)
- mem_ready  in  1  memory can accept a request
- mem_rvalid  in  1  in-order response valid
- mem_rdata  in  DATA_W  response data
- flush  in  1  discard all in-flight requests
- fifo_push  out  1  FIFO push
- fifo_potential_push  out  1  FIFO early write enable
- fifo_data_in  out  attr_t  record to enqueue
- fifo_pop  out  1  FIFO pop
- fifo_valid  in  1  FIFO non-empty
- fifo_full  in  1  FIFO full
- fifo_data_out  in  attr_t  head record
- out_valid  out  1  instruction valid (registered)
- out_pc  out  ADDR_W  instruction PC
- out_data  out  DATA_W  instruction
- outstanding  out  clog2(MAX_OUTSTANDING+1)  in-flight count, for debug and verification

Behaviour:
- FSM states: RUN and DRAIN. Reset state is RUN.
- Reset values: outstanding=0, drain_cnt=0, out_valid=0. out_pc and out_data are don't-care.
- Issue condition, all required: state==RUN, ~flush, req_valid, mem_ready, (~fifo_full | fifo_pop), (outstanding < MAX_OUTSTANDING | resp).
  - req_ready = the issue condition without req_valid.
  - mem_req = fifo_push = issue.
  - Combinational; zero-cycle latency from request to memory.
- fifo_potential_push = req_valid & state==RUN. fifo_data_in = {pc: req_pc}.
- Response: resp = mem_rvalid. fifo_pop = resp.
  - Precondition, asserted: mem_rvalid implies fifo_valid and outstanding > 0.
- outstanding update: outstanding + issue - resp, every cycle. Issue and response in the same cycle leave it unchanged.
- Forwarding: fwd = resp & ~flush & drain_cnt==0 (in DRAIN, drain_cnt is always nonzero).
  - Next cycle: out_valid=fwd, out_pc=fifo_data_out.pc, out_data=mem_rdata.
  - Latency is exactly 1 cycle from mem_rvalid. There is no output backpressure.
- RUN + flush:
  - drain_cnt <= outstanding - resp. The same-cycle response is dropped.
  - If that value is nonzero, go to DRAIN; otherwise stay in RUN.
  - No issue in the flush cycle.
  - out_valid next cycle is 0.
- DRAIN:
  - No issue.
  - Each resp pops the FIFO and decrements drain_cnt; nothing is forwarded.
  - When drain_cnt==1 & resp, go to RUN. Issue is allowed from the following cycle.
- DRAIN + flush: drain_cnt still decrements on resp; no other effect, since every in-flight request is already marked for discard.
- Full boundary: when fifo_full and a resp (pop) occur together, issue is permitted; net occupancy is unchanged.
- Reset mid-operation returns to RUN with zero counts. Stale memory responses after reset are the memory system's responsibility.

Decomposition:
- Shared package fetch_attr_pkg:
  - typedef attr_t (struct: pc[ADDR_W-1:0])
  - localparam MAX_OUTSTANDING_DEFAULT=4
- No sub-module. The FIFO itself is instantiated by the parent, not inside this block.

Test Plan:
- Basic flow: reset, then issue PCs 0x100, 0x104 back-to-back with memory responses 2 cycles later (data 0xA, 0xB) -> out_valid pulses carry (0x100,0xA) then (0x104,0xB), each one cycle after its mem_rvalid; outstanding goes 1,2,…,0.
- Credit limit: hold req_valid with no responses -> exactly 4 issues, then req_ready=0. One response -> one more issue occurs in the same cycle; outstanding stays at 4.
- Full plus pop: FIFO full while resp and req_valid arrive in the same cycle -> fifo_push=1, fifo_pop=1, no overflow; the next head PC is correct.
- Flush with 3 in flight: flush in a cycle with no response -> state DRAIN, drain_cnt=3, req_ready=0.
  - Three responses are dropped (out_valid stays 0).
  - A fourth request issues the cycle after the last dropped response, and its response is forwarded.
- Flush coincident with response, outstanding=1 -> the response is dropped, drain_cnt=0, state stays RUN, the next request issues the following cycle.
- Flush during DRAIN, plus reset in DRAIN:
  - A second flush leaves the drop count unchanged.
  - rst asserted mid-DRAIN -> outstanding=0, out_valid=0, RUN; the next req_valid issues immediately.
